// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a prefix mode
// that latches 21 high bits to extend the following immediate.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit PREFIX_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      a,
    input  logic [4:0]      b,
    input  logic [10:0]     c,
    input  logic [2:0]      imm_sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_pfx_used,
    output logic            err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PFX  = 1'b1;

    logic [0:0]      state_r;
    logic [20:0]     pfx_r;
    logic            out_valid_r;
    logic [XLEN-1:0] out_imm_r;
    logic            out_pfx_used_r;
    logic            err_r;

    logic            in_ready_s;
    logic            accept_s;
    logic [15:0]     cb_s;
    logic [20:0]     cba_s;
    logic            is_pfx_sel_s;
    logic            reserved_s;
    logic            use_pfx_s;
    logic [XLEN-1:0] base_imm_s;
    logic [XLEN-1:0] imm_s;

    assign in_ready_s   = !out_valid_r || out_ready;
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_imm      = out_imm_r;
    assign out_pfx_used = out_pfx_used_r;
    assign err          = err_r;

    // Decode the select and form the candidate immediate for this cycle.
    always_comb begin
        cb_s         = {c, b};
        cba_s        = {c, b, a};
        accept_s     = in_valid && in_ready_s && !flush;
        is_pfx_sel_s = (imm_sel == 3'b101) && (PREFIX_EN == 1'b1);
        reserved_s   = 1'b0;
        base_imm_s   = '0;
        case (imm_sel)
            3'b000: base_imm_s = '0;
            3'b001: base_imm_s = XLEN'($signed({cb_s, 16'h0000}));
            3'b010: base_imm_s = XLEN'($signed(cb_s));
            3'b011: base_imm_s = XLEN'($signed(cba_s));
            3'b100: base_imm_s = XLEN'(cb_s);
            3'b101: reserved_s = (PREFIX_EN == 1'b0);
            default: reserved_s = 1'b1;
        endcase
        use_pfx_s = (state_r == ST_PFX) &&
                    ((imm_sel == 3'b010) || (imm_sel == 3'b011) || (imm_sel == 3'b100));
        if (use_pfx_s) begin
            // Low 16 bits always come from cb; field a is dropped when prefixed.
            imm_s = XLEN'($signed({pfx_r, cb_s}));
        end else begin
            imm_s = base_imm_s;
        end
    end

    // Output register, prefix state and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            pfx_r          <= 21'd0;
            out_valid_r    <= 1'b0;
            out_imm_r      <= '0;
            out_pfx_used_r <= 1'b0;
            err_r          <= 1'b0;
        end else if (flush) begin
            state_r        <= ST_IDLE;
            pfx_r          <= 21'd0;
            out_valid_r    <= 1'b0;
            out_pfx_used_r <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (accept_s) begin
                if (is_pfx_sel_s) begin
                    pfx_r          <= cba_s;
                    state_r        <= ST_PFX;
                    err_r          <= (state_r == ST_PFX);
                    out_valid_r    <= 1'b0;
                    out_pfx_used_r <= 1'b0;
                end else begin
                    out_valid_r    <= 1'b1;
                    out_imm_r      <= imm_s;
                    out_pfx_used_r <= use_pfx_s;
                    state_r        <= ST_IDLE;
                    pfx_r          <= 21'd0;
                    err_r          <= reserved_s;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  a = 5'd0;
    logic [4:0]  b = 5'd0;
    logic [10:0] c = 11'd0;
    logic [2:0]  imm_sel = 3'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_pfx_used, err;
    logic [31:0] out_imm;
    logic        in_ready64, out_valid64, out_pfx_used64, err64;
    logic [63:0] out_imm64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .PREFIX_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .imm_sel(imm_sel), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_pfx_used(out_pfx_used), .err(err)
    );

    imm_gen_pipe #(.XLEN(64), .PREFIX_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .a(a), .b(b), .c(c), .imm_sel(imm_sel), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_pfx_used(out_pfx_used64), .err(err64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [10:0] cv,
                         input logic [4:0] bv, input logic [4:0] av);
        in_valid = 1'b1;
        imm_sel  = sel;
        c        = cv;
        b        = bv;
        a        = av;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        imm_sel  = 3'd0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h expected 0", out_imm); end
        checks++; if (err !== 1'b0 || out_pfx_used !== 1'b0) begin errors++; $display("FAIL reset_err_pfx: got %b/%b expected 0/0", err, out_pfx_used); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_sext();
        out_ready = 1'b1;
        drive(3'b010, 11'h400, 5'h00, 5'h00);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid: got %b expected 1", out_valid); end
        checks++; if (out_imm !== 32'hFFFF8000) begin errors++; $display("FAIL sext_imm: got %h expected FFFF8000", out_imm); end
        checks++; if (out_imm64 !== 64'hFFFFFFFFFFFF8000) begin errors++; $display("FAIL sext_imm64: got %h expected FFFFFFFFFFFF8000", out_imm64); end
        checks++; if (out_pfx_used !== 1'b0) begin errors++; $display("FAIL sext_pfx: got %b expected 0", out_pfx_used); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sext_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(3'b001, 11'h001, 5'h01, 5'h00);
        tick();
        checks++; if (out_imm !== 32'h00210000 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected 00210000/1", out_imm, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        drive(3'b011, 11'h7FF, 5'h1F, 5'h1F);
        tick();
        idle();
        checks++; if (out_imm !== 32'hFFFFFFFF || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected FFFFFFFF/1", out_imm, out_valid); end
        tick();
    endtask

    task automatic test_prefix();
        out_ready = 1'b1;
        drive(3'b101, 11'h000, 5'h00, 5'h01);
        tick();
        checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL pfx_no_out: got %b/%b expected 0/0", out_valid, err); end
        drive(3'b010, 11'h7FF, 5'h1F, 5'h00);
        tick();
        idle();
        checks++; if (out_imm !== 32'h0001FFFF || out_valid !== 1'b1) begin errors++; $display("FAIL pfx_imm: got %h/%b expected 0001FFFF/1", out_imm, out_valid); end
        checks++; if (out_imm64 !== 64'h000000000001FFFF) begin errors++; $display("FAIL pfx_imm64: got %h expected 000000000001FFFF", out_imm64); end
        checks++; if (out_pfx_used !== 1'b1) begin errors++; $display("FAIL pfx_used: got %b expected 1", out_pfx_used); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'b010, 11'h000, 5'h05, 5'h00);
        tick();
        drive(3'b100, 11'h7FF, 5'h00, 5'h00);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        tick();
        tick();
        checks++; if (out_imm !== 32'h00000005 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b expected 00000005/1", out_imm, out_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        idle();
        checks++; if (out_imm !== 32'h0000FFE0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second: got %h/%b expected 0000FFE0/1", out_imm, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        drive(3'b110, 11'h7FF, 5'h1F, 5'h1F);
        tick();
        idle();
        checks++; if (out_imm !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL rsv_imm: got %h/%b expected 0/1", out_imm, out_valid); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b expected 1", err); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rsv_err_clear: got %b expected 0", err); end
    endtask

    task automatic test_prefix_overwrite();
        drive(3'b101, 11'h000, 5'h00, 5'h01);
        tick();
        drive(3'b101, 11'h000, 5'h00, 5'h02);
        tick();
        checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ovr_err: got %b/%b expected 1/0", err, out_valid); end
        drive(3'b011, 11'h000, 5'h03, 5'h07);
        tick();
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_clear: got %b expected 0", err); end
        checks++; if (out_imm !== 32'h00020003 || out_pfx_used !== 1'b1) begin errors++; $display("FAIL ovr_imm: got %h/%b expected 00020003/1", out_imm, out_pfx_used); end
        tick();
    endtask

    task automatic test_prefix_flush();
        drive(3'b101, 11'h000, 5'h00, 5'h05);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(3'b010, 11'h7FF, 5'h1F, 5'h00);
        tick();
        idle();
        checks++; if (out_imm !== 32'hFFFFFFFF || out_pfx_used !== 1'b0) begin errors++; $display("FAIL flush_plain: got %h/%b expected FFFFFFFF/0", out_imm, out_pfx_used); end
        drive(3'b010, 11'h001, 5'h00, 5'h00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_late: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(3'b010, 11'h000, 5'h01, 5'h00);
        tick();
        idle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_imm !== 32'h0) begin errors++; $display("FAIL arst_out: got %b/%h expected 0/0", out_valid, out_imm); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(3'b101, 11'h000, 5'h00, 5'h03);
        tick();
        drive(3'b101, 11'h000, 5'h00, 5'h03);
        tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL arst_pre_err: got %b expected 1", err); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_err: got %b/%b expected 0/0", err, out_valid); end
        @(negedge clk);
        rst = 1'b0;
        drive(3'b010, 11'h7FF, 5'h1F, 5'h00);
        tick();
        idle();
        checks++; if (out_imm !== 32'hFFFFFFFF || out_pfx_used !== 1'b0) begin errors++; $display("FAIL arst_no_pfx: got %h/%b expected FFFFFFFF/0", out_imm, out_pfx_used); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sext();
        test_back_to_back();
        test_prefix();
        test_backpressure();
        test_reserved();
        test_prefix_overwrite();
        test_prefix_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator.
- Takes the same decoded instruction fields (a, b, c) and a widened immediate select, and produces an XLEN-wide immediate behind a one-stage valid/ready register.
- Adds a prefix mode: a prefix instruction latches 21 high bits that extend the next immediate, so immediates wider than 21 bits need no extra ALU work.
- Sits between the decoder and the execute-stage operand mux.

Parameters:
- XLEN, 32, output immediate width; legal values are 32 and 64.
- PREFIX_EN, 1, when 0 the prefix select is treated as reserved and prefix state is never set.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block can accept input this cycle.
- a  in  5  instruction field a.
- b  in  5  instruction field b.
- c  in  11  instruction field c (c[10] is the sign source).
- imm_sel  in  3  immediate select.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  out_imm valid.
- out_ready  in  1  consumer accepts out_imm.
- out_imm  out  XLEN  generated immediate.
- out_pfx_used  out  1  out_imm was extended by a prefix.
- err  out  1  one-cycle pulse on reserved select or prefix-over-prefix.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_imm=0, out_pfx_used=0, err=0, prefix register=0, state=IDLE. in_ready=1 once rst deasserts.
- Field concatenations:
  - cb = {c,b}, 16 bits.
  - cba = {c,b,a}, 21 bits.
  - sext(x) = x sign-extended to XLEN.
- Accept occurs when in_valid && in_ready && !flush.
- in_ready = !out_valid || out_ready, combinational. Output register refills in the same cycle it drains.
- Latency: 1 cycle from accept to out_valid.
- out_imm, out_pfx_used and out_valid hold stable while out_valid && !out_ready.
- imm_sel encoding (no prefix pending):
  - 000: 0.
  - 001: sext({cb,16'b0}) from bit 31.
  - 010: sext(cb).
  - 011: sext(cba).
  - 100: zero-extended cb.
  - 101: PREFIX.
  - 110, 111: reserved. Output is 0, err pulses on the accept cycle +1.
- PREFIX (PREFIX_EN=1):
  - Latches pfx=cba and sets state=PFX.
  - Produces no output: out_valid is not set by this accept, but an already-valid output still drains normally.
  - If state was already PFX, pfx is overwritten and err pulses.
  - With PREFIX_EN=0, 101 behaves as reserved.
- State machine:
  - IDLE: accept 101 -> PFX; any other select -> IDLE.
  - PFX, accept 010/011/100: out_imm = low XLEN bits of sext37({pfx,cb}), out_pfx_used=1, go to IDLE. cba-vs-cb: low 16 bits always come from cb, and a is ignored.
  - PFX, accept 000/001/110/111: normal result per table, prefix discarded, out_pfx_used=0, go to IDLE.
  - PFX, accept 101: overwrite pfx, err pulses, stay in PFX.
- flush=1:
  - Next edge: out_valid=0, out_pfx_used=0, state=IDLE, pfx=0.
  - An input presented in the same cycle is dropped (not accepted).
  - flush overrides out_ready.
- err is registered, high exactly one cycle per offending accept, and independent of out_ready.
- Reset mid-transaction: all state is lost immediately, with no output for in-flight or prefixed inputs.

Test Plan:
- Reset, then sel=010, c=11'h400, b=0 -> next cycle out_valid=1, out_imm=32'hFFFF8000, out_pfx_used=0.
- Back-to-back, out_ready=1:
  - sel=001, c=11'h001, b=5'h01 -> 32'h00210000.
  - Then sel=011, c=11'h7FF, b=5'h1F, a=5'h1F -> 32'hFFFFFFFF on consecutive cycles, with in_ready held 1.
- Prefix: sel=101, c=0, b=0, a=5'h01, then sel=010, c=11'h7FF, b=5'h1F:
  - No output after the first accept.
  - Then out_imm=32'h0001FFFF, out_pfx_used=1.
  - With XLEN=64: 64'h000000000001FFFF.
- Backpressure: out_ready=0, present two inputs -> first result holds stable, in_ready=0, second not accepted. Raise out_ready -> first drains and second is accepted that cycle, appearing one cycle later.
- Error/flush cases:
  - sel=110 -> out_imm=0 and err pulses for exactly one cycle.
  - Prefix then sel=101 -> err pulses and the new pfx is used by the next sel=011.
  - Prefix then flush -> following sel=010 gives plain sext(cb), out_pfx_used=0.
- Assert rst while out_valid=1 and state=PFX -> out_valid, out_imm and err go to 0 asynchronously. The next sel=010 after release yields no prefix extension.
